// File: rtl/mem_read_dma.sv
// mem_read_dma: Avalon-MM read master that fetches consecutive SDRAM words
// and streams them out through a credit-protected FIFO.
module mem_read_dma #(
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] AM_ADDR,
    output logic        AM_READ,
    output logic [2:0]  AM_BURSTCOUNT,
    output logic [3:0]  AM_BYTEENABLE,
    input  logic        AM_WAITREQUEST,
    input  logic [31:0] AM_READDATA,
    input  logic        AM_READDATAVALID,
    input  logic        start,
    input  logic [31:0] start_address,
    input  logic [31:0] number_samples,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        BUSY,
    output logic        FINISHED
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [31:0] DEPTH_U = FIFO_DEPTH;
    localparam logic [31:0] MAXP_U = MAX_PENDING;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   remaining_q, remaining_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;
    logic          req, accept, push, pop;

    // pending+count only grows on acceptance, so a stalled request never loses its credit
    assign req = state_q == ISSUE && remaining_q != 0
              && 32'(pending_q) + 32'(count_q) < DEPTH_U
              && 32'(pending_q) < MAXP_U;
    assign accept = req && !AM_WAITREQUEST;
    assign push = (state_q == ISSUE || state_q == DRAIN) && AM_READDATAVALID && pending_q != 0;
    assign pop = count_q != 0 && out_ready;

    assign AM_READ = req;
    assign AM_ADDR = req ? addr_q : 32'h0;
    assign AM_BURSTCOUNT = 3'd1;
    assign AM_BYTEENABLE = 4'hF;
    assign out_valid = count_q != 0;
    assign out_data = mem_q[rd_ptr_q];
    assign BUSY = busy_q;
    assign FINISHED = finished_q;

    always_comb begin
        state_d = state_q;
        addr_d = accept ? addr_q + 32'd4 : addr_q;
        remaining_d = accept ? remaining_q - 32'd1 : remaining_q;
        pending_d = pending_q + PW'(accept) - PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        busy_d = busy_q;
        finished_d = finished_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d = start_address & ~32'h3;
                remaining_d = number_samples;
                state_d = ISSUE;
                busy_d = 1'b1;
            end
            ISSUE: if (remaining_d == 0) state_d = DRAIN;
            DRAIN: if (pending_q == 0 && count_q == 0) begin
                state_d = FIN;
                busy_d = 1'b0;
                finished_d = 1'b1;
            end
            FIN: if (!start) begin
                state_d = IDLE;
                finished_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q <= '0;
            remaining_q <= '0;
            pending_q <= '0;
            count_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            remaining_q <= remaining_d;
            pending_q <= pending_d;
            count_q <= count_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            busy_q <= busy_d;
            finished_q <= finished_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= AM_READDATA;
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push && !pop) assert (count_q != CW'(FIFO_DEPTH));
    end
endmodule

// File: doc/mem_read_dma.md
Name: mem_read_dma

Overview:
Avalon-MM read-master DMA. It is the playback/readback counterpart of the mic capture DMA. On start it reads number_samples consecutive 32-bit words from SDRAM, beginning at start_address. Read data passes through an internal FIFO and leaves on a valid/ready sample stream that feeds downstream processing or a DAC path. Control inputs come from the same HPS-facing Avalon-MM slave register block, and FINISHED is returned to that block.

Parameters:
FIFO_DEPTH, 8, output FIFO depth in 32-bit words; power of two, minimum 2.
MAX_PENDING, 4, maximum reads accepted by the fabric whose readdatavalid has not yet returned.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
AM_ADDR  out  32  read byte address
AM_READ  out  1  read request
AM_BURSTCOUNT  out  3  constant 3'd1
AM_BYTEENABLE  out  4  constant 4'hF
AM_WAITREQUEST  in  1  fabric stall
AM_READDATA  in  32  returned word
AM_READDATAVALID  in  1  AM_READDATA valid this cycle
start  in  1  level start from the slave register block
start_address  in  32  first byte address; bits [1:0] ignored (forced 0)
number_samples  in  32  word count N; N=0 is a legal empty transfer
out_data  out  32  stream data
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
BUSY  out  1  high from leaving IDLE until entering FIN
FINISHED  out  1  transfer complete

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high (RESET), on clock CLK.
  - Reset values: AM_READ=0, AM_ADDR=0, out_valid=0, BUSY=0, FINISHED=0; FIFO empty; pending=0; state IDLE.
  - Reset mid-transfer aborts immediately. Late AM_READDATAVALID pulses seen while in IDLE or FIN are dropped.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - If start=1: latch addr={start_address[31:2],2'b00} and remaining=number_samples, then go to ISSUE.
  - If the latched remaining is 0, ISSUE goes directly to DRAIN on its first cycle.
- ISSUE, read issue:
  - AM_READ=1 whenever remaining>0 and pending+fifo_count<FIFO_DEPTH (credit check) and pending<MAX_PENDING.
  - AM_ADDR=addr while AM_READ=1, otherwise 0.
  - A read is accepted on a cycle with AM_READ=1 and AM_WAITREQUEST=0. On acceptance: addr+=4 (modulo 2^32, wraps silently), remaining-=1, pending+=1.
  - While AM_WAITREQUEST=1, AM_READ and AM_ADDR hold stable; the credit re-check must not drop a request that is already asserted.
  - ISSUE goes to DRAIN when remaining reaches 0.
- Data return:
  - AM_READDATAVALID=1 (in ISSUE or DRAIN) pushes AM_READDATA into the FIFO and decrements pending.
  - If an acceptance and a return happen in the same cycle, pending is unchanged.
  - Data is returned in order; no tagging is used.
  - The credit rule guarantees the FIFO cannot overflow. An overflow is an assertion failure.
- FIFO and output stream:
  - Registered FIFO. out_valid = FIFO not empty; out_data = head word.
  - A pop occurs when out_valid && out_ready.
  - A word pushed into an empty FIFO becomes visible on out_valid the next cycle.
  - Simultaneous push and pop: count unchanged; legal when full or empty.
  - Read and write pointers wrap at FIFO_DEPTH.
- DRAIN: wait until pending=0 and the FIFO is empty (last word popped), then go to FIN.
- FIN:
  - FINISHED=1, BUSY=0.
  - Stay in FIN while start=1; go to IDLE when start=0. FINISHED falls on that transition.
  - A new start is honoured only after returning to IDLE.
- Streaming during transfer: out_ready may be held low indefinitely. Issue stalls through the credit rule; no data is lost.
- Throughput: with AM_WAITREQUEST=0, return latency L, and out_ready=1, sustains 1 word/cycle while L < MAX_PENDING.

Test Plan:
1. start_address=0x1000, N=4, no stalls, out_ready=1, memory word = address -> reads accepted at 0x1000/04/08/0C; out_data 0x1000..0x100C in order; FINISHED rises once the FIFO is empty; BUSY falls the same cycle.
2. N=0 -> no AM_READ ever; FINISHED=1 within 3 cycles of start; FINISHED clears 1 cycle after start drops.
3. N=20, out_ready=0 for the first 40 cycles -> exactly 8 (FIFO_DEPTH) reads accepted and then AM_READ stays low; after out_ready=1, all 20 words emerge in order with no duplicates or gaps.
4. AM_WAITREQUEST high for 5 cycles on the 2nd read -> AM_ADDR holds 0x1004 and AM_READ holds 1 throughout; remaining decrements only once.
5. start_address=0xFFFFFFFC, N=2 -> addresses 0xFFFFFFFC then 0x00000000; start_address=0x1003 -> first address 0x1000.
6. Assert RESET while 3 reads are pending -> next cycle AM_READ=0, out_valid=0, FINISHED=0; subsequent readdatavalid pulses are ignored; a fresh start with N=2 completes correctly.
